// File: rtl/sn74xxxx_pkg.sv
// Shared definitions for the SN74xxxx-style logic family (counters, decoders, selectors).
package sn74xxxx_pkg;

    localparam int unsigned COUNTER_MAX_WIDTH = 16;

    // Widest counter state, used when counters are cascaded into decoder/selector paths.
    typedef logic [COUNTER_MAX_WIDTH-1:0] counter_state_t;

endpackage : sn74xxxx_pkg

// File: rtl/counter_74161_if.sv
// Control/data bundle of the 74161-style counter.
// CLR_n exists only when COUNTER_74161_SYNC_CLEAR_EN is defined.
interface counter_74161_if #(
    parameter int unsigned WIDTH = 4
);
    import sn74xxxx_pkg::*;

    logic             LOAD_n;
    logic             ENP;
    logic             ENT;
    logic [WIDTH-1:0] D;
`ifdef COUNTER_74161_SYNC_CLEAR_EN
    logic             CLR_n;
`endif
    logic [WIDTH-1:0] Q;
    logic             RCO;

`ifdef COUNTER_74161_SYNC_CLEAR_EN
    modport master (output LOAD_n, ENP, ENT, D, CLR_n, input Q, RCO);
    modport slave  (input LOAD_n, ENP, ENT, D, CLR_n, output Q, RCO);
`else
    modport master (output LOAD_n, ENP, ENT, D, input Q, RCO);
    modport slave  (input LOAD_n, ENP, ENT, D, output Q, RCO);
`endif

endinterface : counter_74161_if

// File: rtl/counter_74161.sv
// Synchronous presettable modulo-N counter with ripple carry (SN74LS161A / K555IE10).
// Define COUNTER_74161_SYNC_CLEAR_EN for the 74LS163-style synchronous clear on CLR_n.
// Cascade by chaining RCO of one stage into ENT of the next at the instantiating level.
module counter_74161
    import sn74xxxx_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic          C,
    input  logic          R,
    counter_74161_if.slave bus
);

    // Reject parameter combinations the counter cannot represent.
    if (WIDTH < 1 || WIDTH > COUNTER_MAX_WIDTH) begin : g_bad_width
        $error("counter_74161: WIDTH=%0d outside 1..%0d", WIDTH, COUNTER_MAX_WIDTH);
    end
    if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus
        $error("counter_74161: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             clr_c;

`ifdef COUNTER_74161_SYNC_CLEAR_EN
    assign clr_c = ~bus.CLR_n;
`else
    assign clr_c = 1'b0;
`endif

    // Next state: clear > load > count > hold. Out-of-range values simply
    // increment and wrap at 2**WIDTH, rejoining the modulo sequence via 0.
    always_comb begin
        count_d = count_q;
        if (clr_c) begin
            count_d = '0;
        end else if (!bus.LOAD_n) begin
            count_d = bus.D;
        end else if (bus.ENP && bus.ENT) begin
            count_d = (count_q == TERM) ? '0 : count_q + WIDTH'(1);
        end
    end

    // State register with asynchronous clear on R.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.Q   = count_q;
    // Carry only at terminal count, gated by ENT so stages ripple correctly.
    assign bus.RCO = bus.ENT & (count_q == TERM);

endmodule : counter_74161
